des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 38 +++
 rtl/des_pc1_perm.sv | 21 ++
 rtl/des_key_schedule.sv | 130 +++++++++++++
 tb/tb_des_key_schedule.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared definitions for the DES key schedule.
//   ks_state_e          : schedule controller states (IDLE / GEN)
//   SHIFT2_MASK_DEFAULT : bit (16-r) set -> round r rotates C/D by 2, else by 1
//   PC1_TAB / PC2_TAB   : standard DES permuted-choice tables, 1-based,
//                         entry i gives the source bit for output bit i
//                         (bit 1 = leftmost/MSB, as in the DES standard)
package des_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } ks_state_e;

  localparam logic [15:0] SHIFT2_MASK_DEFAULT = 16'b0011_1111_0111_1110;

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

endpackage

// File: rtl/des_pc1_perm.sv
// PC-1 permutation: 64-bit DES key -> 56-bit C||D (parity bits dropped).
// Ports:
//   key_in [0:63] : DES key, bit 0 = DES bit 1 (MSB)
//   cd_out [0:55] : C in [0:27], D in [28:55]
module des_pc1_perm
  import des_pkg::*;
(
  input  logic [0:63] key_in,
  output logic [0:55] cd_out
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cd_out = '0;
    for (int i = 0; i < 56; i++) begin
      cd_out[6'(i)] = key_in[6'(PC1_TAB[6'(i)] - 1)];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator. Accepts a key, then streams the 16 round keys
// (K1..K16 for encrypt, K16..K1 for decrypt) over a valid/ready interface.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   key_in, key_valid   : key (parity bits ignored) and its valid strobe
//   key_ready           : high when a key can be accepted
//   decrypt             : key order select, sampled with the key
//   flush               : abort the running schedule / block acceptance
//   rk_out, rk_valid    : current round key (PC-2 of C||D) and valid
//   rk_ready            : consumer accepts rk_out
//   rk_round, rk_last   : emission index 0..15, high on the 16th key
//   busy                : a schedule is in progress
module des_key_schedule
  import des_pkg::*;
#(
  parameter logic [15:0] SHIFT2_MASK = SHIFT2_MASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        decrypt,
  input  logic        flush,
  output logic [0:47] rk_out,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [3:0]  rk_round,
  output logic        rk_last,
  output logic        busy
);

  ks_state_e   state, state_nxt;
  logic [0:27] c_q, d_q;
  logic        dec_q;
  logic [0:55] pc1_cd;
  logic [0:55] cd_cur;
  logic        key_accept;
  logic        rk_fire;
  logic [3:0]  enc_idx;

  des_pc1_perm u_pc1 (
    .key_in (key_in),
    .cd_out (pc1_cd)
  );

  // DES "left" moves bits toward index 0 (the MSB end).
  function automatic logic [0:27] rol28(input logic [0:27] v, input logic by2);
    return by2 ? {v[2:27], v[0:1]} : {v[1:27], v[0]};
  endfunction

  function automatic logic [0:27] ror28(input logic [0:27] v, input logic by2);
    return by2 ? {v[26:27], v[0:25]} : {v[27], v[0:26]};
  endfunction

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (key_valid && !flush)              state_nxt = ST_GEN;
      ST_GEN:  if (flush || (rk_fire && rk_last))    state_nxt = ST_IDLE;
      default:                                       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state == ST_IDLE) && !flush;
    rk_valid  = (state == ST_GEN);
    busy      = (state == ST_GEN);
    rk_last   = (state == ST_GEN) && (rk_round == 4'd15);
  end

  assign key_accept = key_valid && key_ready;
  assign rk_fire    = rk_valid && rk_ready;

  // Encrypt: moving from emitted key rk_round to the next one applies the
  // shift of round rk_round+2, i.e. mask bit 16-(rk_round+2).
  assign enc_idx = 4'd14 - rk_round;

  // ------------------------------------------------------------- datapath
  // Encrypt loads C1/D1 directly; decrypt loads C0/D0, which equals C16/D16
  // because the shifts total 28. Decrypt then walks backwards with right
  // rotates by the shift of round 16-rk_round (mask bit rk_round).
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: C/D are reset so rk_out is defined (zero) straight out of reset.
    if (rst) begin
      c_q      <= '0;
      d_q      <= '0;
      dec_q    <= 1'b0;
      rk_round <= '0;
    end else if (key_accept) begin
      dec_q    <= decrypt;
      rk_round <= '0;
      if (decrypt) begin
        c_q <= pc1_cd[0:27];
        d_q <= pc1_cd[28:55];
      end else begin
        c_q <= rol28(pc1_cd[0:27],  SHIFT2_MASK[15]);
        d_q <= rol28(pc1_cd[28:55], SHIFT2_MASK[15]);
      end
    end else if (rk_fire && !rk_last && !flush) begin
      rk_round <= rk_round + 4'd1;
      if (dec_q) begin
        c_q <= ror28(c_q, SHIFT2_MASK[rk_round]);
        d_q <= ror28(d_q, SHIFT2_MASK[rk_round]);
      end else begin
        c_q <= rol28(c_q, SHIFT2_MASK[enc_idx]);
        d_q <= rol28(d_q, SHIFT2_MASK[enc_idx]);
      end
    end
  end

  // ----------------------------------------------------------------- PC-2
  assign cd_cur = {c_q, d_q};

  always_comb begin
    rk_out = '0;
    for (int j = 0; j < 48; j++) begin
      rk_out[6'(j)] = cd_cur[6'(PC2_TAB[6'(j)] - 1)];
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: directed scenarios plus
// randomized traffic checked every cycle against a textbook DES key-schedule
// model and a transaction-level protocol model.
module tb_des_key_schedule;

  typedef logic [47:0] ks_t [16];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [47:0] KA_1  = 48'h1B02EFFC7072;
  localparam logic [47:0] KA_16 = 48'hCB3D8B0E17F5;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic        decrypt = 1'b0;
  logic        flush = 1'b0;
  logic [47:0] rk_out;
  logic        rk_valid;
  logic        rk_ready = 1'b1;
  logic [3:0]  rk_round;
  logic        rk_last;
  logic        busy;

  int total = 0;
  int bad   = 0;

  des_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .decrypt   (decrypt),
    .flush     (flush),
    .rk_out    (rk_out),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_round  (rk_round),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Textbook DES key schedule on a plain 64-bit value (bit 63 = DES bit 1).
  function automatic ks_t des_subkeys(input logic [63:0] key);
    ks_t         ks;
    logic [27:0] c, d;
    logic [55:0] cd;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = key[64-PC1[i]];
      d[27-i] = key[64-PC1[i+28]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[r][47-j] = cd[56-PC2[j]];
    end
    return ks;
  endfunction

  // ---------------------------------------------------- transaction model
  logic m_gen;
  int   m_round;
  logic m_dec;
  logic m_fresh;
  ks_t  m_keys;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_gen   <= 1'b0;
      m_round <= 0;
      m_dec   <= 1'b0;
      m_fresh <= 1'b1;
    end else if (!m_gen) begin
      if (key_valid && !flush) begin
        m_gen   <= 1'b1;
        m_round <= 0;
        m_dec   <= decrypt;
        m_keys  <= des_subkeys(key_in);
        m_fresh <= 1'b0;
      end
    end else if (flush) begin
      m_gen <= 1'b0;
    end else if (rk_ready) begin
      if (m_round == 15) m_gen   <= 1'b0;
      else               m_round <= m_round + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("key_ready", key_ready, !m_gen && !flush);
      check("busy",      busy,      m_gen);
      check("rk_valid",  rk_valid,  m_gen);
      check("rk_last",   rk_last,   m_gen && (m_round == 15));
      if (m_gen) begin
        check("rk_round", rk_round, 64'(m_round));
        check("rk_out", rk_out, m_dec ? m_keys[15-m_round] : m_keys[m_round]);
      end else if (m_fresh) begin
        check("idle_rk_out",   rk_out,   '0);
        check("idle_rk_round", rk_round, '0);
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [63:0] k, input logic dec);
    key_in    = k;
    decrypt   = dec;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  ks_t ka;
  ks_t kb;
  logic [63:0] key_b;

  initial begin
    ka = des_subkeys(KEY_A);
    check("model_k1",  ka[0],  KA_1);
    check("model_k16", ka[15], KA_16);
    check("model_k2",  ka[1],  48'h79AED9DBC9E5);

    // reset values before any clock edge
    #1;
    check("rst_rk_valid",  rk_valid,  0);
    check("rst_busy",      busy,      0);
    check("rst_rk_out",    rk_out,    0);
    check("rst_rk_round",  rk_round,  0);
    check("rst_rk_last",   rk_last,   0);
    check("rst_key_ready", key_ready, 1);
    tick(2);
    rst = 1'b0;
    tick();

    // encrypt, consumer always ready
    start_key(KEY_A, 1'b0);
    check("enc_first_valid", rk_valid, 1);
    check("enc_first_round", rk_round, 0);
    check("enc_first_key",   rk_out,   KA_1);
    tick(15);
    check("enc_last_key",   rk_out,   KA_16);
    check("enc_last_flag",  rk_last,  1);
    check("enc_last_round", rk_round, 15);
    tick();
    check("enc_done_valid", rk_valid,  0);
    check("enc_done_ready", key_ready, 1);

    // decrypt, same key
    start_key(KEY_A, 1'b1);
    check("dec_first_key", rk_out, KA_16);
    for (int r = 1; r < 16; r++) begin
      tick();
      check("dec_key", rk_out, ka[15-r]);
    end
    check("dec_last_key",  rk_out,  KA_1);
    check("dec_last_flag", rk_last, 1);
    tick();

    // stall at round 5
    start_key(KEY_A, 1'b0);
    tick(5);
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_round", rk_round, 5);
      check("stall_key",   rk_out,   ka[5]);
    end
    rk_ready = 1'b1;
    tick();
    check("after_stall_round", rk_round, 6);
    check("after_stall_key",   rk_out,   ka[6]);
    tick(10);
    check("stall_done_valid", rk_valid, 0);

    // flush at round 7, then a new key restarts at round 0
    start_key(KEY_A, 1'b0);
    tick(7);
    check("pre_flush_round", rk_round, 7);
    flush = 1'b1;
    tick();
    check("flush_valid", rk_valid, 0);
    check("flush_busy",  busy,     0);
    key_b     = {$urandom, $urandom};
    kb        = des_subkeys(key_b);
    key_in    = key_b;
    decrypt   = 1'b0;
    key_valid = 1'b1;
    #1;
    check("flush_idle_key_ready", key_ready, 0);
    tick();
    check("flush_idle_not_taken", busy, 0);
    flush = 1'b0;
    tick();
    key_valid = 1'b0;
    check("restart_round", rk_round, 0);
    check("restart_key",   rk_out,   kb[0]);
    tick(16);

    // asynchronous reset at round 9
    start_key(key_b, 1'b1);
    tick(9);
    check("pre_rst_round", rk_round, 9);
    #1;
    rst = 1'b1;
    #1;
    check("arst_rk_valid", rk_valid, 0);
    check("arst_busy",     busy,     0);
    check("arst_rk_out",   rk_out,   0);
    check("arst_rk_round", rk_round, 0);
    check("arst_rk_last",  rk_last,  0);
    #1;
    rst = 1'b0;
    tick();
    start_key(KEY_A, 1'b0);
    check("post_rst_round", rk_round, 0);
    check("post_rst_key",   rk_out,   KA_1);
    tick(16);

    // key_valid held high through a whole schedule with changing keys
    key_in    = KEY_A;
    decrypt   = 1'b0;
    key_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      key_in = {$urandom, $urandom};
    end
    key_valid = 1'b0;
    tick(20);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      key_valid = ($urandom_range(0, 1) == 1);
      key_in    = {$urandom, $urandom};
      decrypt   = ($urandom_range(0, 1) == 1);
      rk_ready  = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 24) == 0);
      tick();
    end
    key_valid = 1'b0;
    flush     = 1'b0;
    rk_ready  = 1'b1;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
